regfile_xfer: RTL and testbench
===============================

Name: regfile_xfer

Overview:
- Initiator side of the byte-serial register-file port: turns one word-wide core request (read rs1/rs2, optional write rd) into a 4-phase byte transfer over the 8-bit rs1_dat/rs2_dat/rd_dat buses.
- Owns and drives the mux_phase sequence.
- Deserialises read bytes into 32-bit operands and serialises the write word.
- Sits between the core's decode/execute logic and register_file.

Parameters:
- XLEN, 32, register width in bits; must be a multiple of 8.
- AW, 4, register address width (16 registers).
- NPH, XLEN/8, phases per transfer (localparam, derived); phase counter width PW = clog2(NPH) = 2.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; synchronous, active-low
- req_valid  input  1  core requests a transfer
- req_ready  output  1  request accepted this cycle when req_valid && req_ready
- req_rs1  input  AW  source register 1
- req_rs2  input  AW  source register 2
- req_rd  input  AW  destination register
- req_we  input  1  write req_wdata to req_rd
- req_wdata  input  XLEN  write data
- rsp_valid  output  1  one-cycle pulse: operands complete
- rsp_rs1_val  output  XLEN  assembled rs1 value, stable until next rsp_valid
- rsp_rs2_val  output  XLEN  assembled rs2 value, stable until next rsp_valid
- rf_mux_phase  output  PW  byte phase to register_file
- rf_rs1  output  AW  to register_file
- rf_rs2  output  AW  to register_file
- rf_rd  output  AW  to register_file
- rf_rd_we  output  1  byte write enable to register_file
- rf_rd_dat  output  8  write byte to register_file
- rf_rs1_dat  input  8  read byte from register_file
- rf_rs2_dat  input  8  read byte from register_file

Behaviour:
- Protocol: in phase k (0..NPH-1), byte k = bits [8k+7:8k].
  - register_file drives rs1/rs2 byte k combinationally.
  - register_file writes rd byte k at the clock edge ending phase k when rf_rd_we=1.
- Reset (rst_n=0 at posedge):
  - State IDLE, phase 0.
  - req_ready=1, rsp_valid=0, rf_rd_we=0, rf_rd_dat=0.
  - rf_rs1/rf_rs2/rf_rd=0, rsp_*_val=0.
  - A partial transfer is discarded; no further bytes are written.
- FSM: IDLE, XFER.
  - IDLE: req_ready=1. On req_valid, latch rs1/rs2/rd/we/wdata, go XFER with phase=0.
  - XFER: phase increments each cycle. Capture rf_rs1_dat/rf_rs2_dat into byte [phase] of the assembly registers.
  - XFER, phase=NPH-1: req_ready=1.
    - On req_valid, latch the new request; phase wraps to 0 and the FSM stays in XFER (back-to-back, one transfer per NPH cycles).
    - Otherwise go IDLE with phase 0.
- rf_rs1/rf_rs2/rf_rd/rf_mux_phase come from the latched request and counter (registered); constant for the whole transfer.
- rf_rd_dat = latched wdata byte[phase] in XFER, 0 in IDLE.
- rf_rd_we = latched we && (latched rd != 0) in XFER, else 0. Writes to x0 are suppressed here.
- rsp_valid: registered; pulses for 1 cycle on the cycle after phase NPH-1.
  - rsp_*_val update on the same edge as the final byte capture.
  - Latency: request accept edge to rsp_valid = NPH+1 cycles (5).
- Read-before-write: if rs1 or rs2 equals rd with we=1, the response returns the OLD value. Each byte is read before that byte's write edge.
- x0 reads: passed through from register_file (no forcing here).
- req_valid high outside the accept windows is ignored; the core must hold the request until it is accepted.

Decomposition:
- Shared package rf_pkg:
  - XLEN, AW, NPH, PW constants.
  - phase_t typedef.
  - State enum {IDLE, XFER}.
  - byte_lane(word, k) function, shared with register_file.
- One natural sub-module: byte_deser (NPH-byte shift/assembly register with lane-select write, instantiated twice for rs1 and rs2).

Test Plan:
- Reset mid-transfer: assert rst_n=0 at phase 2 of a we=1 transfer -> next cycle rf_rd_we=0, phase=0, rsp_valid never pulses, register keeps its pre-transfer bytes 2..3.
- Basic read: preload x3=0xDEADBEEF, x5=0x01234567; request rs1=3, rs2=5, we=0 -> phases 0,1,2,3 seen. Then rsp_valid exactly once, 5 cycles after accept, with rsp_rs1_val=0xDEADBEEF and rsp_rs2_val=0x01234567.
- Write: rd=7, we=1, wdata=0xA5B6C7D8 -> rf_rd_dat sequence D8,C7,B6,A5 with rf_rd_we=1. A later read of x7 returns 0xA5B6C7D8.
- x0 write: rd=0, we=1, wdata=0xFFFFFFFF -> rf_rd_we stays 0 all phases; x0 reads 0.
- Read-before-write: x4=0x11111111; request rs1=4, rd=4, we=1, wdata=0x22222222 -> rsp_rs1_val=0x11111111. The next read of x4 returns 0x22222222.
- Back-to-back: req_valid held high with two requests -> second accepted at phase 3. Phases run 0..3,0..3 with no gap; rsp_valid pulses at cycle 5 and cycle 9 after the first accept.

Source files
------------

// File: rtl/regfile_xfer_pkg.sv
// rtl/regfile_xfer_pkg.sv - shared constants, types and byte-lane helper for the register-file byte port
package rf_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 4;
    localparam int NPH  = XLEN / 8;
    localparam int PW   = $clog2(NPH);

    typedef logic [PW-1:0] phase_t;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam phase_t LAST_PHASE = phase_t'(NPH - 1);

    // Byte k of a word; register_file uses the same lane ordering.
    function automatic logic [7:0] byte_lane(input logic [XLEN-1:0] word, input phase_t k);
        return word[{k, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/regfile_xfer_if.sv
// rtl/regfile_xfer_if.sv - core request/response and register_file byte bus bundle
//   master: the transfer initiator (drives req_ready, rsp_*, rf_* outputs)
//   slave : core + register_file side (drives req_*, rf_rs1_dat, rf_rs2_dat)
interface regfile_xfer_if;
    import rf_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic [AW-1:0]   req_rs1;
    logic [AW-1:0]   req_rs2;
    logic [AW-1:0]   req_rd;
    logic            req_we;
    logic [XLEN-1:0] req_wdata;

    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rs1_val;
    logic [XLEN-1:0] rsp_rs2_val;

    phase_t          rf_mux_phase;
    logic [AW-1:0]   rf_rs1;
    logic [AW-1:0]   rf_rs2;
    logic [AW-1:0]   rf_rd;
    logic            rf_rd_we;
    logic [7:0]      rf_rd_dat;
    logic [7:0]      rf_rs1_dat;
    logic [7:0]      rf_rs2_dat;

    modport master (
        input  req_valid, req_rs1, req_rs2, req_rd, req_we, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rs1_val, rsp_rs2_val,
        output rf_mux_phase, rf_rs1, rf_rs2, rf_rd, rf_rd_we, rf_rd_dat,
        input  rf_rs1_dat, rf_rs2_dat
    );

    modport slave (
        output req_valid, req_rs1, req_rs2, req_rd, req_we, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rs1_val, rsp_rs2_val,
        input  rf_mux_phase, rf_rs1, rf_rs2, rf_rd, rf_rd_we, rf_rd_dat,
        output rf_rs1_dat, rf_rs2_dat
    );

endinterface

// File: rtl/regfile_xfer_byte_deser.sv
// rtl/regfile_xfer_byte_deser.sv - byte-lane assembly register with publish of the completed word
//   clk, rst_n : clock, synchronous active-low reset
//   en         : capture din into byte lane 'lane'
//   lane       : byte lane being captured
//   din        : incoming byte
//   publish    : this capture completes the word; update 'word'
//   word       : last completed word, held until the next publish
module byte_deser
    import rf_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  phase_t          lane,
    input  logic [7:0]      din,
    input  logic            publish,
    output logic [XLEN-1:0] word
);

    logic [NPH-1:0][7:0] asm_q;
    logic [NPH-1:0][7:0] merged;

    // The final byte is folded in here so the published word updates on
    // the same edge that captures it, one cycle earlier than reading asm_q.
    always_comb begin
        merged       = asm_q;
        merged[lane] = din;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            asm_q <= '0;
            word  <= '0;
        end else if (en) begin
            asm_q[lane] <= din;
            if (publish) begin
                word <= merged;
            end
        end
    end

endmodule

// File: rtl/regfile_xfer.sv
// rtl/regfile_xfer.sv - initiator of the byte-serial register-file transfer
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : regfile_xfer_if.master (core request/response + register_file byte bus)
module regfile_xfer
    import rf_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    regfile_xfer_if.master  bus
);

    state_t          state;
    phase_t          phase;
    logic            req_ready_q;
    logic            rsp_valid_q;
    logic [AW-1:0]   rs1_q;
    logic [AW-1:0]   rs2_q;
    logic [AW-1:0]   rd_q;
    logic            rd_we_q;
    logic [7:0]      rd_dat_q;
    logic [XLEN-1:0] wdata_q;

    logic accept;
    logic last;

    assign accept = bus.req_valid && req_ready_q;
    assign last   = (state == XFER) && (phase == LAST_PHASE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            phase       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            rd_we_q     <= 1'b0;
            rd_dat_q    <= '0;
            wdata_q     <= '0;
        end else begin
            rsp_valid_q <= last;
            if (accept) begin
                // Covers both IDLE and the back-to-back slot at the last phase.
                state       <= XFER;
                phase       <= '0;
                req_ready_q <= (LAST_PHASE == '0);
                rs1_q       <= bus.req_rs1;
                rs2_q       <= bus.req_rs2;
                rd_q        <= bus.req_rd;
                wdata_q     <= bus.req_wdata;
                rd_we_q     <= bus.req_we && (bus.req_rd != '0);
                rd_dat_q    <= byte_lane(bus.req_wdata, '0);
            end else if (state == XFER) begin
                if (last) begin
                    state       <= IDLE;
                    phase       <= '0;
                    req_ready_q <= 1'b1;
                    rd_we_q     <= 1'b0;
                    rd_dat_q    <= '0;
                end else begin
                    phase       <= phase + 1'b1;
                    req_ready_q <= ((phase + 1'b1) == LAST_PHASE);
                    rd_dat_q    <= byte_lane(wdata_q, phase + 1'b1);
                end
            end
        end
    end

    byte_deser u_deser_rs1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (state == XFER),
        .lane    (phase),
        .din     (bus.rf_rs1_dat),
        .publish (last),
        .word    (bus.rsp_rs1_val)
    );

    byte_deser u_deser_rs2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (state == XFER),
        .lane    (phase),
        .din     (bus.rf_rs2_dat),
        .publish (last),
        .word    (bus.rsp_rs2_val)
    );

    assign bus.req_ready    = req_ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rf_mux_phase = phase;
    assign bus.rf_rs1       = rs1_q;
    assign bus.rf_rs2       = rs2_q;
    assign bus.rf_rd        = rd_q;
    assign bus.rf_rd_we     = rd_we_q;
    assign bus.rf_rd_dat    = rd_dat_q;

endmodule

// File: tb/tb_regfile_xfer.sv
// tb/tb_regfile_xfer.sv - directed self-checking bench for regfile_xfer
module tb_regfile_xfer;
    import rf_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_xfer_if bus ();

    regfile_xfer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [XLEN-1:0] regs [0:(1<<AW)-1];
    logic            ld_en = 1'b0;
    logic [AW-1:0]   ld_addr = '0;
    logic [XLEN-1:0] ld_data = '0;

    always_comb bus.rf_rs1_dat = byte_lane(regs[bus.rf_rs1], bus.rf_mux_phase);
    always_comb bus.rf_rs2_dat = byte_lane(regs[bus.rf_rs2], bus.rf_mux_phase);

    always @(posedge clk) begin
        if (ld_en) begin
            regs[ld_addr] <= ld_data;
        end else if (rst_n && bus.rf_rd_we) begin
            regs[bus.rf_rd][{bus.rf_mux_phase, 3'b000} +: 8] <= bus.rf_rd_dat;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Called at a negedge while idle; returns at the negedge one cycle after rsp_valid.
    task automatic run_xfer(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                            input logic [AW-1:0] rd, input logic we, input logic [31:0] wdata,
                            input logic [31:0] exp1, input logic [31:0] exp2);
        logic [31:0] w;
        w = wdata;
        bus.req_valid = 1'b1;
        bus.req_rs1   = rs1;
        bus.req_rs2   = rs2;
        bus.req_rd    = rd;
        bus.req_we    = we;
        bus.req_wdata = wdata;
        check("ready_idle", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check("phase", 32'(bus.rf_mux_phase), 32'(c - 1));
            check("rd_we", 32'(bus.rf_rd_we), 32'(we && rd != 0));
            check("rd_dat", 32'(bus.rf_rd_dat), 32'(w[8*(c-1) +: 8]));
            check("rsp_early", 32'(bus.rsp_valid), 32'd0);
            @(negedge clk);
        end
        check("rsp_pulse", 32'(bus.rsp_valid), 32'd1);
        check("rsp_rs1", bus.rsp_rs1_val, exp1);
        check("rsp_rs2", bus.rsp_rs2_val, exp2);
        @(negedge clk);
        check("rsp_once", 32'(bus.rsp_valid), 32'd0);
        check("rsp_hold", bus.rsp_rs1_val, exp1);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) regs[i] = '0;
        bus.req_valid = 1'b0;
        bus.req_rs1   = '0;
        bus.req_rs2   = '0;
        bus.req_rd    = '0;
        bus.req_we    = 1'b0;
        bus.req_wdata = '0;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp", 32'(bus.rsp_valid), 32'd0);
        check("rst_we", 32'(bus.rf_rd_we), 32'd0);
        check("rst_dat", 32'(bus.rf_rd_dat), 32'd0);
        check("rst_phase", 32'(bus.rf_mux_phase), 32'd0);
        check("rst_rd", 32'(bus.rf_rd), 32'd0);
        check("rst_val1", bus.rsp_rs1_val, 32'd0);
        rst_n = 1'b1;

        preload(4'd3, 32'hDEADBEEF);
        preload(4'd5, 32'h01234567);
        preload(4'd4, 32'h11111111);
        @(negedge clk);

        // basic read
        run_xfer(4'd3, 4'd5, 4'd0, 1'b0, 32'h0, 32'hDEADBEEF, 32'h01234567);
        // write x7, then read it back
        run_xfer(4'd7, 4'd0, 4'd7, 1'b1, 32'hA5B6C7D8, 32'h0, 32'h0);
        run_xfer(4'd7, 4'd3, 4'd0, 1'b0, 32'h0, 32'hA5B6C7D8, 32'hDEADBEEF);
        // x0 write suppressed
        run_xfer(4'd0, 4'd0, 4'd0, 1'b1, 32'hFFFFFFFF, 32'h0, 32'h0);
        run_xfer(4'd0, 4'd5, 4'd0, 1'b0, 32'h0, 32'h0, 32'h01234567);
        // read-before-write
        run_xfer(4'd4, 4'd5, 4'd4, 1'b1, 32'h22222222, 32'h11111111, 32'h01234567);
        run_xfer(4'd4, 4'd0, 4'd0, 1'b0, 32'h0, 32'h22222222, 32'h0);

        // back-to-back: A read at cycle 0, B held until accepted at phase 3
        bus.req_valid = 1'b1;
        bus.req_rs1 = 4'd3; bus.req_rs2 = 4'd5; bus.req_rd = 4'd0;
        bus.req_we = 1'b0; bus.req_wdata = 32'h0;
        @(negedge clk);
        bus.req_rs1 = 4'd7; bus.req_rs2 = 4'd4; bus.req_rd = 4'd9;
        bus.req_we = 1'b1; bus.req_wdata = 32'h0BADF00D;
        for (int c = 1; c <= 4; c++) begin
            check("b2b_phase_a", 32'(bus.rf_mux_phase), 32'(c - 1));
            check("b2b_ready", 32'(bus.req_ready), 32'(c == 4));
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        check("b2b_rsp_a", 32'(bus.rsp_valid), 32'd1);
        check("b2b_a_rs1", bus.rsp_rs1_val, 32'hDEADBEEF);
        check("b2b_a_rs2", bus.rsp_rs2_val, 32'h01234567);
        check("b2b_phase_b0", 32'(bus.rf_mux_phase), 32'd0);
        check("b2b_we_b", 32'(bus.rf_rd_we), 32'd1);
        check("b2b_dat_b0", 32'(bus.rf_rd_dat), 32'h0D);
        for (int c = 6; c <= 8; c++) begin
            @(negedge clk);
            check("b2b_phase_b", 32'(bus.rf_mux_phase), 32'(c - 5));
            check("b2b_gap", 32'(bus.rsp_valid), 32'd0);
        end
        @(negedge clk);
        check("b2b_rsp_b", 32'(bus.rsp_valid), 32'd1);
        check("b2b_b_rs1", bus.rsp_rs1_val, 32'hA5B6C7D8);
        check("b2b_b_rs2", bus.rsp_rs2_val, 32'h22222222);
        @(negedge clk);
        check("b2b_x9", regs[9], 32'h0BADF00D);

        // reset at phase 2 of a write to x9
        bus.req_valid = 1'b1;
        bus.req_rs1 = 4'd0; bus.req_rs2 = 4'd0; bus.req_rd = 4'd9;
        bus.req_we = 1'b1; bus.req_wdata = 32'h11223344;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_phase2", 32'(bus.rf_mux_phase), 32'd2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_we", 32'(bus.rf_rd_we), 32'd0);
        check("mid_phase", 32'(bus.rf_mux_phase), 32'd0);
        check("mid_ready", 32'(bus.req_ready), 32'd1);
        for (int c = 0; c < 4; c++) begin
            check("mid_norsp", 32'(bus.rsp_valid), 32'd0);
            @(negedge clk);
        end
        check("mid_x9", regs[9], 32'h0BAD3344);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
